// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage data bank: FSM states and the response record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

  // Deepest response pipe the bank supports.
  localparam int RD_LAT_MAX = 4;

  // Default word width, and the widest word a response record can carry.
  localparam int DATA_W_DEF = 32;
  localparam int RSP_DATA_W = 64;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // rdata is sized for the widest word. Narrower banks zero-extend on entry
  // and truncate on exit, so the upper bits are constant and fold away.
  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [RSP_DATA_W-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Fixed-latency delay line that carries one response record per accepted request.
// Latency: exactly RD_LAT cycles from rsp_in to rsp_out.
// Backpressure: none. It shifts every cycle, and rst drops every record in flight.
module dmem_rsp_pipe
  import dmem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  rsp_t rsp_in,
  output rsp_t rsp_out
);

  rsp_t stage [RD_LAT];

  // Advance one stage per cycle. Reset clears every stage so nothing stale is emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= rsp_in;
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign rsp_out = stage[RD_LAT-1];

endmodule

// File: rtl/dmem_bank_sync.sv
// Clocked MEM-stage data bank: byte-masked writes, range check, and a zero sweep after reset.
// Latency: RD_LAT cycles from accept to the response pulse, with strict in-order responses.
// Backpressure: req_ready is low only during the DEPTH-cycle clear sweep. Optional DMEM_PARITY_EN adds per-byte parity.
module dmem_bank_sync
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
`ifdef DMEM_PARITY_EN
  ,
  input  logic                inj_par_err
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  // Reject parameter sets the datapath cannot honour.
  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("dmem_bank_sync: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
  end
  if ((DATA_W % 8) != 0 || DATA_W > RSP_DATA_W) begin : g_bad_data_w
    $error("dmem_bank_sync: DATA_W=%0d must be a multiple of 8 and <= %0d", DATA_W, RSP_DATA_W);
  end
  if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $error("dmem_bank_sync: DEPTH=%0d does not fit ADDR_W=%0d", DEPTH, ADDR_W);
  end

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  clr_cnt;
  logic              last_clr;
  logic              accept;
  logic              in_range;
  logic              wr_en;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic              par_fault;
  rsp_t              rsp_in;
  rsp_t              rsp_out;

  logic [DATA_W-1:0] mem [DEPTH];

  assign last_clr = (clr_cnt == IDX_W'(DEPTH - 1));
  assign accept   = req_valid & req_ready;
  // The upper address bits only feed the range check. In-range addresses never set them.
  assign in_range = ({1'b0, req_addr} < DEPTH_V);
  assign idx      = req_addr[IDX_W-1:0];
  assign wr_en    = accept & req_we & in_range;
  assign rd_word  = mem[idx];

  // State register. The clear counter walks the array once per reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) begin
        clr_cnt <= clr_cnt + IDX_W'(1);
      end
    end
  end

  // Next state: leave the sweep after the last word is cleared. RUN is terminal until reset.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (last_clr) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // FSM outputs: the bank takes requests only once the sweep is done.
  always_comb begin
    req_ready = (state == ST_RUN);
  end

  // Array write port: zero sweep in INIT, byte-masked request writes in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[clr_cnt] <= '0;
      end else if (wr_en) begin
        for (int b = 0; b < NB; b++) begin
          if (req_be[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] par_mis;

  // Parity write port. It follows the data sweep and byte mask. inj_par_err stores deliberately wrong parity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        par[clr_cnt] <= '0;
      end else if (wr_en) begin
        for (int b = 0; b < NB; b++) begin
          if (req_be[b]) par[idx][b] <= (^req_wdata[8*b +: 8]) ^ inj_par_err;
        end
      end
    end
  end

  // Recompute even parity per byte of the addressed word and compare it with the stored bits.
  always_comb begin
    par_mis = '0;
    for (int b = 0; b < NB; b++) begin
      par_mis[b] = par[idx][b] ^ (^rd_word[8*b +: 8]);
    end
  end

  assign par_fault = |par_mis;
`else
  assign par_fault = 1'b0;
`endif

  // Build the response record at accept time. Writes and range errors return zero data.
  always_comb begin
    rsp_in = '0;
    if (accept) begin
      rsp_in.valid = 1'b1;
      if (!in_range) begin
        rsp_in.err = 1'b1;
      end else if (!req_we) begin
        rsp_in.err   = par_fault;
        rsp_in.rdata = RSP_DATA_W'(rd_word);
      end
    end
  end

  dmem_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .rsp_in  (rsp_in),
    .rsp_out (rsp_out)
  );

  assign rsp_valid = rsp_out.valid;
  assign rsp_err   = rsp_out.err;
  assign rsp_rdata = DATA_W'(rsp_out.rdata);

endmodule

// File: tb/tb_dmem_bank_sync.sv
// Bench for dmem_bank_sync. A queue/array reference model predicts ready, response timing and data.
// Latency: the model expects each response RD_LAT cycles after its accept.
// Backpressure: the model expects ready to be low for DEPTH cycles after every reset.
module tb_dmem_bank_sync;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 128;
  localparam int RL    = 3;
  localparam int NB    = DW / 8;
`ifdef DMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [NB-1:0] req_be;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
`ifdef DMEM_PARITY_EN
  logic          inj_par_err;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_bank_sync #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEPTH),
    .RD_LAT (RL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
`ifdef DMEM_PARITY_EN
    ,
    .inj_par_err (inj_par_err)
`endif
  );

  typedef struct { int due; logic err; logic [DW-1:0] data; } exp_t;
  typedef struct { logic r; logic v; logic we; int addr; logic [DW-1:0] wd; logic [NB-1:0] be; logic inj; } req_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_mem [DEPTH];
  logic [NB-1:0] m_bad [DEPTH];
  int            rst_cyc = 0;
  int            checks  = 0;
  int            errors  = 0;
  logic          e_rdy, e_v, e_e;
  logic [DW-1:0] e_d;
  req_t          seq[$];

  function automatic req_t mk(input logic r, input logic v, input logic we, input int addr,
                              input logic [DW-1:0] wd, input logic [NB-1:0] be, input logic inj);
    req_t q;
    q.r = r; q.v = v; q.we = we; q.addr = addr; q.wd = wd; q.be = be; q.inj = inj;
    return q;
  endfunction

  function automatic req_t rd(input int a);
    return mk(1'b0, 1'b1, 1'b0, a, '0, '0, 1'b0);
  endfunction

  function automatic req_t wr(input int a, input logic [DW-1:0] d, input logic [NB-1:0] be, input logic inj);
    return mk(1'b0, 1'b1, 1'b1, a, d, be, inj);
  endfunction

  function automatic req_t idle();
    return mk(1'b0, 1'b0, 1'b0, 0, '0, '0, 1'b0);
  endfunction

  function automatic req_t rs();
    return mk(1'b1, 1'b0, 1'b0, 0, '0, '0, 1'b0);
  endfunction

  // Drive one cycle of stimulus at the falling edge, update the reference model,
  // then wait one cycle and publish what the outputs should show now.
  task automatic step(input req_t q);
    exp_t e;
    rst       = q.r;
    req_valid = q.v;
    req_we    = q.we;
    req_addr  = AW'(q.addr);
    req_wdata = q.wd;
    req_be    = q.be;
`ifdef DMEM_PARITY_EN
    inj_par_err = q.inj;
`endif
    if (q.r) begin
      exp_q.delete();
      rst_cyc = cyc + 1;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_bad[i] = '0;
      end
    end else if (q.v && cyc >= rst_cyc + DEPTH) begin
      e.due  = cyc + RL;
      e.err  = 1'b0;
      e.data = '0;
      if (q.addr >= DEPTH) begin
        e.err = 1'b1;
      end else if (q.we) begin
        for (int b = 0; b < NB; b++) begin
          if (q.be[b]) begin
            m_mem[q.addr][8*b +: 8] = q.wd[8*b +: 8];
            m_bad[q.addr][b] = q.inj;
          end
        end
      end else begin
        e.data = m_mem[q.addr];
        e.err  = PAR && (m_bad[q.addr] != '0);
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    e_rdy = (cyc >= rst_cyc + DEPTH);
    e_v = 1'b0; e_e = 1'b0; e_d = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      e_v = 1'b1; e_e = e.err; e_d = e.data;
    end
  endtask

  task automatic test_reset();
    int low;
    for (int i = 0; i < 3; i++) begin
      step(rs());
      checks++;
      if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_rdata !== '0) begin
        errors++;
        $display("FAIL reset_values cyc=%0d rdy=%b vld=%b err=%b data=%h required all zero", cyc, req_ready, rsp_valid, rsp_err, rsp_rdata);
      end
    end
    low = 0;
    while (req_ready === 1'b0 && low < 300) begin
      low++;
      step(idle());
      checks++;
      if (req_ready !== e_rdy || rsp_valid !== e_v) begin
        errors++;
        $display("FAIL init_sweep cyc=%0d rdy=%b/%b vld=%b/%b (got/exp)", cyc, req_ready, e_rdy, rsp_valid, e_v);
      end
    end
    checks++;
    if (low != DEPTH) begin
      errors++;
      $display("FAIL init_length got %0d cycles of ready low, required %0d", low, DEPTH);
    end
    seq = {};
    seq.push_back(rd(5));
    for (int i = 0; i <= RL; i++) seq.push_back(idle());
    foreach (seq[i]) begin
      step(seq[i]);
      checks++;
      if (req_ready !== e_rdy || rsp_valid !== e_v || (e_v && (rsp_err !== e_e || rsp_rdata !== e_d))) begin
        errors++;
        $display("FAIL read_after_init cyc=%0d rdy=%b/%b vld=%b/%b err=%b/%b data=%h/%h (got/exp)", cyc, req_ready, e_rdy, rsp_valid, e_v, rsp_err, e_e, rsp_rdata, e_d);
      end
    end
  endtask

  task automatic test_rw_bytes();
    int nrsp = 0;
    seq = {};
    seq.push_back(wr(3, 32'hDEADBEEF, 4'b1111, 1'b0));
    seq.push_back(wr(3, 32'h11223344, 4'b0101, 1'b0));
    seq.push_back(rd(3));
    seq.push_back(wr(4, 32'h55667788, 4'b0000, 1'b0));
    seq.push_back(rd(4));
    for (int i = 0; i <= RL; i++) seq.push_back(idle());
    foreach (seq[i]) begin
      step(seq[i]);
      checks++;
      if (req_ready !== e_rdy || rsp_valid !== e_v || (e_v && (rsp_err !== e_e || rsp_rdata !== e_d))) begin
        errors++;
        $display("FAIL byte_write cyc=%0d rdy=%b/%b vld=%b/%b err=%b/%b data=%h/%h (got/exp)", cyc, req_ready, e_rdy, rsp_valid, e_v, rsp_err, e_e, rsp_rdata, e_d);
      end
      if (rsp_valid === 1'b1) begin
        nrsp++;
        if (nrsp == 3) begin
          checks++;
          if (rsp_rdata !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL byte_merge got %h required de22be44", rsp_rdata);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int drv0, first = -1, nrsp = 0;
    seq = {};
    seq.push_back(wr(0, 32'h0000A000, 4'hF, 1'b0));
    seq.push_back(wr(1, 32'h0000B001, 4'hF, 1'b0));
    seq.push_back(wr(2, 32'h0000C002, 4'hF, 1'b0));
    for (int i = 0; i <= RL; i++) seq.push_back(idle());
    seq.push_back(rd(0));
    seq.push_back(rd(1));
    seq.push_back(rd(2));
    for (int i = 0; i <= RL; i++) seq.push_back(idle());
    drv0 = 0;
    foreach (seq[i]) begin
      if (i == RL + 4) drv0 = cyc;
      step(seq[i]);
      checks++;
      if (req_ready !== e_rdy || rsp_valid !== e_v || (e_v && (rsp_err !== e_e || rsp_rdata !== e_d))) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d rdy=%b/%b vld=%b/%b err=%b/%b data=%h/%h (got/exp)", cyc, req_ready, e_rdy, rsp_valid, e_v, rsp_err, e_e, rsp_rdata, e_d);
      end
      if (i >= RL + 4 && rsp_valid === 1'b1) begin
        nrsp++;
        if (first < 0) first = cyc;
      end
    end
    checks++;
    if (first - drv0 != RL || nrsp != 3) begin
      errors++;
      $display("FAIL read_latency got latency %0d with %0d responses, required %0d with 3", first - drv0, nrsp, RL);
    end
  endtask

  task automatic test_out_of_range();
    seq = {};
    seq.push_back(rd(200));
    seq.push_back(wr(200, 32'hFFFFFFFF, 4'hF, 1'b0));
    seq.push_back(wr(128, 32'hFFFFFFFF, 4'hF, 1'b0));
    seq.push_back(rd(72));
    seq.push_back(rd(0));
    seq.push_back(rd(3));
    seq.push_back(rd(127));
    seq.push_back(rd(128));
    seq.push_back(rd(255));
    for (int i = 0; i <= RL; i++) seq.push_back(idle());
    foreach (seq[i]) begin
      step(seq[i]);
      checks++;
      if (req_ready !== e_rdy || rsp_valid !== e_v || (e_v && (rsp_err !== e_e || rsp_rdata !== e_d))) begin
        errors++;
        $display("FAIL out_of_range cyc=%0d rdy=%b/%b vld=%b/%b err=%b/%b data=%h/%h (got/exp)", cyc, req_ready, e_rdy, rsp_valid, e_v, rsp_err, e_e, rsp_rdata, e_d);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int late = 0;
    seq = {};
    seq.push_back(wr(10, 32'hCAFEF00D, 4'hF, 1'b0));
    for (int i = 0; i <= RL; i++) seq.push_back(idle());
    seq.push_back(rd(10));
    seq.push_back(rd(10));
    seq.push_back(rs());
    for (int i = 0; i < DEPTH + 2; i++) seq.push_back(idle());
    seq.push_back(rd(10));
    for (int i = 0; i <= RL; i++) seq.push_back(idle());
    foreach (seq[i]) begin
      step(seq[i]);
      checks++;
      if (req_ready !== e_rdy || rsp_valid !== e_v || (e_v && (rsp_err !== e_e || rsp_rdata !== e_d))) begin
        errors++;
        $display("FAIL reset_flush cyc=%0d rdy=%b/%b vld=%b/%b err=%b/%b data=%h/%h (got/exp)", cyc, req_ready, e_rdy, rsp_valid, e_v, rsp_err, e_e, rsp_rdata, e_d);
      end
      if (i > RL + 3 && i < RL + 6 + DEPTH && rsp_valid === 1'b1) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL dropped_responses got %0d responses after reset, required 0", late);
    end
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    int nrsp = 0;
    seq = {};
    seq.push_back(wr(7, 32'hA5A5A5A5, 4'b1111, 1'b0));
    seq.push_back(wr(7, 32'hA5A5A5A5, 4'b0001, 1'b1));
    seq.push_back(rd(7));
    seq.push_back(wr(7, 32'hA5A5A5A5, 4'b0001, 1'b0));
    seq.push_back(rd(7));
    for (int i = 0; i <= RL; i++) seq.push_back(idle());
    foreach (seq[i]) begin
      step(seq[i]);
      checks++;
      if (req_ready !== e_rdy || rsp_valid !== e_v || (e_v && (rsp_err !== e_e || rsp_rdata !== e_d))) begin
        errors++;
        $display("FAIL parity cyc=%0d rdy=%b/%b vld=%b/%b err=%b/%b data=%h/%h (got/exp)", cyc, req_ready, e_rdy, rsp_valid, e_v, rsp_err, e_e, rsp_rdata, e_d);
      end
      if (rsp_valid === 1'b1) begin
        nrsp++;
        if (nrsp == 3) begin
          checks++;
          if (rsp_err !== 1'b1 || rsp_rdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL parity_inject got err=%b data=%h required err=1 data=a5a5a5a5", rsp_err, rsp_rdata);
          end
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    req_t q;
    int   a;
    seq = {};
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 4) == 0) ? int'($urandom_range(120, 255)) : int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        q = idle();
      end else if ($urandom_range(0, 1) == 0) begin
        q = wr(a, $urandom, NB'($urandom_range(0, (1 << NB) - 1)), PAR && ($urandom_range(0, 7) == 0));
      end else begin
        q = rd(a);
      end
      seq.push_back(q);
    end
    for (int i = 0; i <= RL; i++) seq.push_back(idle());
    foreach (seq[i]) begin
      step(seq[i]);
      checks++;
      if (req_ready !== e_rdy || rsp_valid !== e_v || (e_v && (rsp_err !== e_e || rsp_rdata !== e_d))) begin
        errors++;
        $display("FAIL random cyc=%0d rdy=%b/%b vld=%b/%b err=%b/%b data=%h/%h (got/exp)", cyc, req_ready, e_rdy, rsp_valid, e_v, rsp_err, e_e, rsp_rdata, e_d);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
`ifdef DMEM_PARITY_EN
    inj_par_err = 1'b0;
`endif
    test_reset();
    test_rw_bytes();
    test_back_to_back();
    test_out_of_range();
    test_reset_midflight();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete by time %0t", $time);
    $fatal(1);
  end

endmodule
